// File: rtl/result_display_if.sv
// Handshake and display bundle between the ALU side and result_display.
// The master drives the conversion request; the slave returns the display.
interface result_display_if #(
    parameter int WIDTH = 9
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             o_flag_in;
    logic             busy;
    logic             done;
    logic [13:0]      ss;
    logic             red;
    logic             blue;

    modport master (
        output start,
        output value,
        output o_flag_in,
        input  busy,
        input  done,
        input  ss,
        input  red,
        input  blue
    );

    modport slave (
        input  start,
        input  value,
        input  o_flag_in,
        output busy,
        output done,
        output ss,
        output red,
        output blue
    );
endinterface

// File: rtl/result_display.sv
// Two's-complement result to two seven-segment digits.
// Sequential double-dabble with start/busy/done; display holds last value.
module result_display #(
    parameter int WIDTH         = 9,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic            clk,
    input  logic            nrst,
    result_display_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [13:0] SS_RST  = {7'h00, 7'h3F};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] r_mag;
    logic [11:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_nz;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [13:0]      r_ss;
    logic             r_red;
    logic             r_blue;

    logic [WIDTH-1:0] w_abs;
    logic [11:0]      w_bcd_adj;
    logic             w_err;
    logic [6:0]       w_seg_tens;
    logic [6:0]       w_seg_ones;

    function automatic logic [6:0] f_seg(input logic [3:0] i_d);
        logic [6:0] w_s;
        case (i_d)
            4'd0:    w_s = 7'h3F;
            4'd1:    w_s = 7'h06;
            4'd2:    w_s = 7'h5B;
            4'd3:    w_s = 7'h4F;
            4'd4:    w_s = 7'h66;
            4'd5:    w_s = 7'h6D;
            4'd6:    w_s = 7'h7D;
            4'd7:    w_s = 7'h07;
            4'd8:    w_s = 7'h7F;
            4'd9:    w_s = 7'h6F;
            default: w_s = SEG_OFF;
        endcase
        return w_s;
    endfunction

    function automatic logic [11:0] f_add3(input logic [11:0] i_b);
        logic [11:0] w_b;
        w_b = i_b;
        for (int i = 0; i < 3; i++) begin
            if (w_b[4*i +: 4] >= 4'd5) begin
                w_b[4*i +: 4] = w_b[4*i +: 4] + 4'd3;
            end
        end
        return w_b;
    endfunction

    // -256 negates to itself, which reads correctly as unsigned 256.
    assign w_abs = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1))
                                      : bus.value;

    assign w_bcd_adj = f_add3(r_bcd);

    assign w_err = r_ovf | (r_bcd[11:8] != 4'd0);

    assign w_seg_ones = f_seg(r_bcd[3:0]);
    assign w_seg_tens = (BLANK_LEADING && (r_bcd[7:4] == 4'd0))
                      ? SEG_OFF : f_seg(r_bcd[7:4]);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture, shift-add-3 conversion and display update.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_nz   <= 1'b0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ss   <= SS_RST;
            r_red  <= 1'b0;
            r_blue <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mag  <= w_abs;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_neg  <= bus.value[WIDTH-1];
                r_nz   <= |bus.value;
                r_ovf  <= bus.o_flag_in;
                r_busy <= 1'b1;
            end else if (r_state == S_SHIFT) begin
                {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                r_cnt          <= r_cnt + CNT_W'(1);
            end else if (r_state == S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_red  <= w_err;
                r_blue <= r_neg & r_nz;
                r_ss   <= w_err ? {SEG_DASH, SEG_DASH}
                                : {w_seg_tens, w_seg_ones};
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ss   = r_ss;
    assign bus.red  = r_red;
    assign bus.blue = r_blue;

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display, both leading-zero options side by side.
// Expected displays come from a decimal model of the signed result.
module tb_result_display;

    typedef struct {
        logic [13:0] ss;
        logic        red;
        logic        blue;
    } exp_t;

    logic       clk;
    logic       nrst;
    logic       t_start;
    logic [8:0] t_value;
    logic       t_ovf;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q1[$];
    exp_t q0[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic [13:0] last1 = 14'h003F;
    logic [13:0] last0 = 14'h003F;

    result_display_if #(.WIDTH(9)) u_if1 ();
    result_display_if #(.WIDTH(9)) u_if0 ();

    assign u_if1.start     = t_start;
    assign u_if1.value     = t_value;
    assign u_if1.o_flag_in = t_ovf;
    assign u_if0.start     = t_start;
    assign u_if0.value     = t_value;
    assign u_if0.o_flag_in = t_ovf;

    result_display #(.WIDTH(9), .BLANK_LEADING(1'b1)) u_dut1 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if1)
    );

    result_display #(.WIDTH(9), .BLANK_LEADING(1'b0)) u_dut0 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (u_if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [8:0] v, input logic ovf,
                                   input bit blank);
        exp_t e;
        int   s;
        int   m;
        int   tens;
        int   ones;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        e.red  = ovf || (m > 99);
        e.blue = (s < 0);
        if (e.red) begin
            e.ss = {7'h40, 7'h40};
        end else begin
            tens = m / 10;
            ones = m % 10;
            e.ss[6:0]  = seg_tab[ones];
            e.ss[13:7] = (blank && tens == 0) ? 7'h00 : seg_tab[tens];
        end
        return e;
    endfunction

    // Monitor: score every done pulse and watch the display while busy.
    always @(negedge clk) begin
        exp_t e;
        if (u_if1.busy) chk("hold1", u_if1.ss, last1);
        if (u_if0.busy) chk("hold0", u_if0.ss, last0);
        last1 = u_if1.ss;
        last0 = u_if0.ss;
        if (u_if1.done) begin
            if (q1.size() == 0) begin
                chk("spurious_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("ss1", u_if1.ss, e.ss);
                chk("red1", u_if1.red, e.red);
                chk("blue1", u_if1.blue, e.blue);
            end
        end
        if (u_if0.done) begin
            if (q0.size() == 0) begin
                chk("spurious_done0", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("ss0", u_if0.ss, e.ss);
                chk("red0", u_if0.red, e.red);
                chk("blue0", u_if0.blue, e.blue);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ss1"}, u_if1.ss, 14'h003F);
        chk({tag, "_ss0"}, u_if0.ss, 14'h003F);
        chk({tag, "_red"}, u_if1.red, 0);
        chk({tag, "_blue"}, u_if1.blue, 0);
        chk({tag, "_busy"}, u_if1.busy, 0);
        chk({tag, "_done"}, u_if1.done, 0);
    endtask

    // Called at a negedge. inj>0 raises start with 99 for edge k+inj;
    // abrt>0 pulls reset between edges k+abrt-1 and k+abrt.
    task automatic run(input logic [8:0] v, input logic f,
                       input int inj, input int abrt);
        bit seen;
        seen    = 0;
        t_start = 1'b1;
        t_value = v;
        t_ovf   = f;
        q1.push_back(model(v, f, 1'b1));
        q0.push_back(model(v, f, 1'b0));
        @(negedge clk);
        t_start = 1'b0;
        chk("busy_accept", u_if1.busy, 1);
        for (int c = 1; c <= 15 && !seen; c++) begin
            if (c == inj) begin
                t_start = 1'b1;
                t_value = 9'd99;
            end
            if (c == inj + 1) begin
                t_start = 1'b0;
            end
            if (c == abrt) begin
                nrst = 1'b0;
                #1;
                chk_reset_outputs("abort");
                q1.delete();
                q0.delete();
                @(negedge clk);
                chk("abort_nodone", u_if1.done, 0);
                nrst = 1'b1;
                return;
            end
            @(negedge clk);
            if (c == 9) chk("busy_last", u_if1.busy, 1);
            if (u_if1.done) begin
                seen = 1;
                chk("latency", c, 10);
                chk("busy_end", u_if1.busy, 0);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [8:0] v;
        logic       f;
        nrst    = 1'b0;
        t_start = 1'b0;
        t_value = '0;
        t_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        run(9'd42, 1'b0, 0, 0);
        run(9'h1F9, 1'b0, 0, 0);
        run(9'd150, 1'b0, 0, 0);
        run(9'h100, 1'b0, 0, 0);
        run(9'd5, 1'b1, 0, 0);
        run(9'd42, 1'b0, 4, 0);
        chk("ignored_ss", u_if1.ss, {7'h66, 7'h5B});
        run(9'd99, 1'b0, 0, 0);
        run(9'd42, 1'b0, 0, 5);
        @(negedge clk);
        run(9'd0, 1'b0, 0, 0);
        run(9'h19C, 1'b0, 0, 0);
        run(9'd100, 1'b0, 0, 0);
        run(9'h19D, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                v = 9'($urandom_range(0, 511));
            end else begin
                v = 9'($urandom_range(0, 198) - 99);
            end
            f = ($urandom_range(0, 7) == 0);
            run(v, f, 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("drain1", q1.size(), 0);
        chk("drain0", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Display-side counterpart of the keypad encoder: converts the ALU's 9-bit two's-complement result back into decimal digits on two seven-segment displays.
- Conversion is sequential double-dabble (binary to BCD) with a start/busy/done handshake.
- The display holds the last completed value until a new conversion finishes.
- Sits between the ALU/operand buffer and the pins driving ss, red and blue.

Parameters:
- WIDTH, 9, input value width (two's complement); shift iterations per conversion.
- BLANK_LEADING, 1, 1 = blank the tens digit when it is zero; 0 = show a leading "0".

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- value  input  WIDTH  two's-complement result; captured on accepted start.
- o_flag_in  input  1  ALU overflow; captured on accepted start.
- busy  output  1  high from the accepting edge until the outputs-update edge.
- done  output  1  one-cycle pulse when new outputs are valid.
- ss  output  14  ss[6:0] = ones digit, ss[13:7] = tens digit; segment bit0 = a … bit6 = g; active-high.
- red  output  1  error indicator.
- blue  output  1  negative indicator.

Behaviour:
- Reset (async, nrst low):
  - state = IDLE; busy = 0, done = 0, red = 0, blue = 0.
  - ss = {7'h00, 7'h3F}, i.e. a blank tens digit and "0" ones digit.
  - Internal registers cleared.
- IDLE:
  - start = 1 at edge k → capture mag = |value| (9-bit unsigned; -256 gives 256), neg = value[WIDTH-1], ovf = o_flag_in.
  - Also clear the 12-bit BCD register (3 digits) and the iteration counter; busy = 1; go to SHIFT.
- SHIFT:
  - Each edge, for every BCD digit ≥ 5 add 3, then shift {bcd, mag} left by one; counter increments.
  - After WIDTH shifts (edges k+1 … k+9) go to DONE.
- DONE (edge k+10): update the registered outputs, busy = 0, done = 1 for exactly one cycle, go to IDLE.
  - Latency: start sampled at edge k → outputs and done valid after edge k+10.
  - A new start may be accepted at edge k+11.
- Output rules applied in DONE:
  - err = ovf OR (hundreds BCD digit ≠ 0).
  - red = err.
  - blue = neg AND (mag ≠ 0); no negative zero.
  - If err: ss = {7'h40, 7'h40} (two dashes).
  - Else: ones digit = seg(ones); tens digit = seg(tens), or 7'h00 if tens = 0 and BLANK_LEADING = 1.
- Segment codes, 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- start while busy (SHIFT or DONE): ignored; value and o_flag_in are not resampled.
- start held continuously: a new conversion begins each time the block re-enters IDLE.
- Reset mid-conversion: abort immediately, all outputs take their reset values, no done pulse.
- ss, red and blue change only in DONE or on reset; they are stable while busy.

Test Plan:
- Reset → ss = 14'h003F, red = 0, blue = 0, busy = 0, done = 0.
- value = 42, start pulse → busy high for 10 cycles; done pulses once after edge k+10; ss = {7'h66, 7'h5B}; red = 0, blue = 0.
- value = 9'h1F9 (-7) → ss = {7'h00, 7'h07}, blue = 1. With BLANK_LEADING = 0 → ss = {7'h3F, 7'h07}.
- Error cases:
  - value = 150 → red = 1, ss = {7'h40, 7'h40}, blue = 0.
  - value = 9'h100 (-256) → red = 1, blue = 1.
  - value = 5 with o_flag_in = 1 → red = 1, ss = dashes.
- value = 42 start, then value = 99 with start at edge k+4 → second start ignored; ss shows 42; a new start after done converts 99 → {7'h6F, 7'h6F}.
- Conversion of 42 in progress, nrst low at edge k+5 → outputs return to reset values at once, no done pulse. Then value = 0 → ss = 14'h003F, blue = 0.
